// File: rtl/lstm_mem_pkg.sv
// rtl/lstm_mem_pkg.sv - shared types, memory map and descriptor helpers for the LSTM memory subsystem
package lstm_mem_pkg;

  localparam int ELEMENT_BITS = 8;
  localparam int ADDR_BITS    = 11;
  localparam int RAM_DEPTH    = 2048;
  localparam int FEATURES     = 4;
  localparam int CYCLES       = 10;
  localparam int WEIGHTS      = 64;
  localparam int OUT_WORDS    = 8;
  localparam int IDX_BITS     = $clog2(CYCLES);

  localparam int IN_FIRST  = 0;
  localparam int W1_FIRST  = FEATURES * CYCLES;
  localparam int W2_FIRST  = W1_FIRST + WEIGHTS;
  localparam int OUT_FIRST = W2_FIRST + WEIGHTS;

  typedef enum logic [2:0] {
    OP_IDLE      = 3'd0,
    OP_LOAD_W1   = 3'd1,
    OP_LOAD_W2   = 3'd2,
    OP_LOAD_IN   = 3'd3,
    OP_STORE_OUT = 3'd4
  } op_mode_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] first_addr;
    logic [ADDR_BITS-1:0] count;
    dir_e                 dir;
  } xfer_desc_t;

  function automatic logic is_xfer_op(input logic [2:0] op);
    return (op >= 3'(OP_LOAD_W1)) && (op <= 3'(OP_STORE_OUT));
  endfunction

  function automatic logic [IDX_BITS-1:0] idx_inc(input logic [IDX_BITS-1:0] idx);
    return (idx == IDX_BITS'(CYCLES - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Codes outside 1-4 yield an empty descriptor; the sequencer never issues them.
  function automatic xfer_desc_t make_desc(input logic [2:0] op,
                                           input logic [IDX_BITS-1:0] in_idx,
                                           input logic [IDX_BITS-1:0] out_idx);
    xfer_desc_t d;
    d.first_addr = '0;
    d.count      = '0;
    d.dir        = DIR_READ;
    case (op)
      3'(OP_LOAD_W1): begin
        d.first_addr = ADDR_BITS'(W1_FIRST);
        d.count      = ADDR_BITS'(WEIGHTS);
      end
      3'(OP_LOAD_W2): begin
        d.first_addr = ADDR_BITS'(W2_FIRST);
        d.count      = ADDR_BITS'(WEIGHTS);
      end
      3'(OP_LOAD_IN): begin
        d.first_addr = ADDR_BITS'(IN_FIRST + FEATURES * int'(in_idx));
        d.count      = ADDR_BITS'(FEATURES);
      end
      3'(OP_STORE_OUT): begin
        d.first_addr = ADDR_BITS'(OUT_FIRST + OUT_WORDS * int'(out_idx));
        d.count      = ADDR_BITS'(OUT_WORDS);
        d.dir        = DIR_WRITE;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lstm_dpr.sv
// rtl/lstm_dpr.sv - simple dual-port RAM with registered read data
module lstm_dpr
  import lstm_mem_pkg::*;
#(
  parameter int DW    = ELEMENT_BITS,
  parameter int AW    = ADDR_BITS,
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cs_in_i,
  input  logic          we_in_i,
  input  logic [AW-1:0] addr_in_i,
  input  logic [DW-1:0] data_in_i,
  input  logic          cs_out_i,
  input  logic          oe_out_i,
  input  logic [AW-1:0] addr_out_i,
  output logic [DW-1:0] data_out_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (cs_in_i && we_in_i) begin
      mem_q[addr_in_i] <= data_in_i;
    end
  end

  // Read samples the array before any same-edge write lands, so collisions return old data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out_o <= '0;
    end else if (cs_out_i && oe_out_i) begin
      data_out_o <= mem_q[addr_out_i];
    end
  end

endmodule

// File: rtl/lstm_mem_dma_subsys.sv
// rtl/lstm_mem_dma_subsys.sv - op_mode sequencer plus DMA engine in front of the main RAM
module lstm_mem_dma_subsys
  import lstm_mem_pkg::*;
(
  input  logic                    fpga_clk,
  input  logic                    reset_n,
  input  logic                    sys_start,
  input  logic [2:0]              op_mode,
  input  logic                    host_we,
  input  logic [ADDR_BITS-1:0]    host_addr,
  input  logic [ELEMENT_BITS-1:0] host_data,
  input  logic [ELEMENT_BITS-1:0] core_wdata,
  output logic [ELEMENT_BITS-1:0] core_rdata,
  output logic                    core_rvalid,
  output logic                    core_wreq,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {DMA_IDLE, DMA_RD, DMA_WR, DMA_DONE} dma_state_e;

  logic [2:0]              mode_q, mode_d;
  logic [IDX_BITS-1:0]     in_idx_q, in_idx_d;
  logic [IDX_BITS-1:0]     out_idx_q, out_idx_d;
  logic                    start;
  xfer_desc_t              desc;

  dma_state_e              state_q, state_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [ADDR_BITS-1:0]    left_q, left_d;
  logic                    rd_oe;
  logic                    wr_en_q;
  logic [ADDR_BITS-1:0]    wr_addr_q;
  logic                    rvalid_q;
  logic                    done_q;
  logic                    dma_idle;

  logic                    ram_we;
  logic [ADDR_BITS-1:0]    ram_waddr;
  logic [ELEMENT_BITS-1:0] ram_wdata;

  assign dma_idle = (state_q == DMA_IDLE);

  always_comb begin
    mode_d    = mode_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    start     = 1'b0;
    desc      = make_desc(op_mode, in_idx_q, out_idx_q);
    if (dma_idle) begin
      if (!is_xfer_op(op_mode)) begin
        mode_d = '0;
      end else if (sys_start && (op_mode != mode_q)) begin
        start  = 1'b1;
        mode_d = op_mode;
        if (op_mode == 3'(OP_LOAD_IN))   in_idx_d  = idx_inc(in_idx_q);
        if (op_mode == 3'(OP_STORE_OUT)) out_idx_d = idx_inc(out_idx_q);
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      mode_q    <= '0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
    end else begin
      mode_q    <= mode_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    rd_oe     = 1'b0;
    core_wreq = 1'b0;
    case (state_q)
      DMA_IDLE: begin
        if (start) begin
          addr_d  = desc.first_addr;
          left_d  = desc.count;
          state_d = (desc.dir == DIR_WRITE) ? DMA_WR : DMA_RD;
        end
      end
      DMA_RD, DMA_WR: begin
        rd_oe     = (state_q == DMA_RD);
        core_wreq = (state_q == DMA_WR);
        addr_d    = addr_q + 1'b1;
        left_d    = left_q - 1'b1;
        if (left_q == ADDR_BITS'(1)) state_d = DMA_DONE;
      end
      DMA_DONE: state_d = DMA_IDLE;
      default:  state_d = DMA_IDLE;
    endcase
    // Losing sys_start abandons the transfer without a completion pulse.
    if (!sys_start) begin
      state_d   = DMA_IDLE;
      rd_oe     = 1'b0;
      core_wreq = 1'b0;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      state_q   <= DMA_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rvalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      wr_en_q   <= core_wreq;
      wr_addr_q <= addr_q;
      rvalid_q  <= rd_oe;
      done_q    <= (state_q == DMA_DONE) && sys_start;
    end
  end

  // Write address/enable trail core_wreq by one cycle to meet the core's data.
  assign ram_we    = sys_start ? wr_en_q    : host_we;
  assign ram_waddr = sys_start ? wr_addr_q  : host_addr;
  assign ram_wdata = sys_start ? core_wdata : host_data;

  lstm_dpr u_ram (
    .clk        (fpga_clk),
    .rstn       (reset_n),
    .cs_in_i    (1'b1),
    .we_in_i    (ram_we),
    .addr_in_i  (ram_waddr),
    .data_in_i  (ram_wdata),
    .cs_out_i   (sys_start),
    .oe_out_i   (rd_oe),
    .addr_out_i (addr_q),
    .data_out_o (core_rdata)
  );

  assign core_rvalid = rvalid_q;
  assign busy        = !dma_idle;
  assign done        = done_q;

endmodule

// File: tb/tb_lstm_mem_dma_subsys.sv
// tb/tb_lstm_mem_dma_subsys.sv - scoreboard bench for the LSTM memory subsystem
module tb_lstm_mem_dma_subsys;

  logic        fpga_clk = 1'b0;
  logic        reset_n;
  logic        sys_start;
  logic [2:0]  op_mode;
  logic        host_we;
  logic [10:0] host_addr;
  logic [7:0]  host_data;
  logic [7:0]  core_wdata;
  logic [7:0]  core_rdata;
  logic        core_rvalid;
  logic        core_wreq;
  logic        busy;
  logic        done;

  lstm_mem_dma_subsys u_dut (
    .fpga_clk    (fpga_clk),
    .reset_n     (reset_n),
    .sys_start   (sys_start),
    .op_mode     (op_mode),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .core_wreq   (core_wreq),
    .busy        (busy),
    .done        (done)
  );

  always #5 fpga_clk = ~fpga_clk;

  int total = 0;
  int bad   = 0;
  int rv_cnt = 0;
  int ref_mem [2048];
  int in_idx = 0;
  int out_idx = 0;
  int exp_q[$];
  int wdata_q[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every word the DUT presents is matched against the scoreboard queue.
  always @(negedge fpga_clk) begin
    if (core_rvalid) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata_unexpected: actual=%0d required=none", core_rdata);
      end else begin
        chk("rdata", int'(core_rdata), exp_q.pop_front());
      end
    end
  end

  // Core model: answers each core_wreq with the next queued word one cycle later.
  initial begin
    bit pend;
    pend = 1'b0;
    core_wdata = 8'h00;
    forever begin
      @(negedge fpga_clk);
      if (pend && wdata_q.size() > 0) core_wdata = 8'(wdata_q.pop_front());
      pend = core_wreq;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_xfer(input int op, input bit fixed_store);
    int first, cnt, cyc, a, d;
    bit is_wr, seen;
    is_wr = 1'b0;
    first = 0;
    cnt   = 0;
    case (op)
      1: begin first = 40;  cnt = 64; end
      2: begin first = 104; cnt = 64; end
      3: begin first = in_idx * 4; cnt = 4; in_idx = (in_idx + 1) % 10; end
      default: begin first = 168 + out_idx * 8; cnt = 8; is_wr = 1'b1; out_idx = (out_idx + 1) % 10; end
    endcase
    for (int k = 0; k < cnt; k++) begin
      a = (first + k) % 2048;
      if (!is_wr) begin
        exp_q.push_back(ref_mem[a]);
      end else begin
        d = fixed_store ? (8'hA0 + k) : int'($urandom_range(0, 255));
        wdata_q.push_back(d);
        ref_mem[a] = d;
      end
    end
    rv_cnt  = 0;
    op_mode = 3'(op);
    cyc     = 0;
    seen    = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge fpga_clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    chk("done_latency", cyc, cnt + 2);
    chk("rvalid_count", rv_cnt, is_wr ? 0 : cnt);
    chk("busy_at_done", int'(busy), 0);
    if (is_wr) begin
      @(negedge fpga_clk);
      for (int k = 0; k < cnt; k++) begin
        a = (first + k) % 2048;
        chk("store_mem", int'(u_dut.u_ram.mem_q[a]), ref_mem[a]);
      end
    end
  endtask

  task automatic do_idle(input int code);
    op_mode = 3'(code);
    repeat (2) @(negedge fpga_clk);
  endtask

  initial begin
    int busy_cnt, c;
    reset_n   = 1'b0;
    sys_start = 1'b0;
    op_mode   = 3'd0;
    host_we   = 1'b0;
    host_addr = '0;
    host_data = '0;
    repeat (3) @(negedge fpga_clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rvalid", int'(core_rvalid), 0);
    chk("reset_wreq", int'(core_wreq), 0);
    chk("reset_rdata", int'(core_rdata), 0);
    reset_n = 1'b1;

    // Host preload while op_mode asks for a transfer that must not happen.
    for (int a = 0; a < 2048; a++) ref_mem[a] = 0;
    for (int a = 0; a < 168; a++) begin
      if (a < 8)        ref_mem[a] = a + 1;
      else if (a < 40)  ref_mem[a] = int'($urandom_range(0, 255));
      else if (a < 60)  ref_mem[a] = 4;
      else if (a < 80)  ref_mem[a] = 3;
      else if (a < 104) ref_mem[a] = 2;
      else              ref_mem[a] = int'($urandom_range(0, 255));
    end
    op_mode  = 3'd1;
    busy_cnt = 0;
    for (int a = 0; a < 168; a++) begin
      host_we   = 1'b1;
      host_addr = 11'(a);
      host_data = 8'(ref_mem[a]);
      @(negedge fpga_clk);
      if (busy) busy_cnt++;
    end
    host_we = 1'b0;
    chk("no_xfer_when_stopped", busy_cnt, 0);
    op_mode = 3'd0;
    @(negedge fpga_clk);
    sys_start = 1'b1;
    @(negedge fpga_clk);

    host_we   = 1'b1;
    host_addr = 11'd45;
    host_data = 8'h99;
    @(negedge fpga_clk);
    host_we = 1'b0;
    @(negedge fpga_clk);
    chk("host_blocked", int'(u_dut.u_ram.mem_q[45]), ref_mem[45]);

    do_xfer(1, 1'b0);
    busy_cnt = 0;
    repeat (5) begin
      @(negedge fpga_clk);
      if (busy) busy_cnt++;
    end
    chk("same_mode_no_reissue", busy_cnt, 0);
    do_idle(0);

    do_xfer(3, 1'b0);
    do_idle(0);
    do_xfer(3, 1'b0);
    do_idle(0);
    do_xfer(4, 1'b1);
    do_idle(0);
    do_xfer(4, 1'b0);
    do_idle(0);

    // Eight more LOAD_IN bring the count to ten; the eleventh wraps to address 0.
    for (int i = 0; i < 9; i++) begin
      do_xfer(3, 1'b0);
      do_idle(0);
    end

    for (int i = 0; i < 16; i++) begin
      do_xfer(int'($urandom_range(1, 4)), 1'b0);
      c = int'($urandom_range(0, 3));
      do_idle(c == 0 ? 0 : c + 4);
    end

    // Reset in the middle of a LOAD_W1 read.
    for (int k = 0; k < 64; k++) exp_q.push_back(ref_mem[40 + k]);
    op_mode = 3'd1;
    repeat (10) @(negedge fpga_clk);
    reset_n = 1'b0;
    op_mode = 3'd0;
    @(negedge fpga_clk);
    reset_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rvalid", int'(core_rvalid), 0);
    chk("abort_done", int'(done), 0);
    exp_q.delete();
    in_idx  = 0;
    out_idx = 0;
    @(negedge fpga_clk);
    do_xfer(1, 1'b0);
    do_idle(0);
    do_xfer(3, 1'b0);
    do_idle(0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lstm_mem_dma_subsys.md
Name: lstm_mem_dma_subsys

Overview:
Memory subsystem feeding the LSTM accelerator core. It has three parts:
- an 8-bit x 2048-word dual-port RAM (main memory);
- a command sequencer that turns the core's op_mode into block-transfer descriptors;
- a DMA engine that streams words between RAM and the core.

A host write port preloads the RAM while the system is not started.

Parameters:
- ELEMENT_BITS, 8, data word width.
- ADDR_BITS, 11, RAM address width.
- RAM_DEPTH, 2048, RAM words.
- FEATURES, 4, words per input vector.
- CYCLES, 10, input vectors per sequence.
- WEIGHTS, 64, words per weight matrix.
- OUT_WORDS, 8, words per output vector.

Ports:
- fpga_clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sys_start  in  1  0 = host owns the RAM write port; 1 = DMA owns it. Level.
- op_mode  in  3  transfer request from the core.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_BITS  host write address.
- host_data  in  ELEMENT_BITS  host write data.
- core_wdata  in  ELEMENT_BITS  data from the core for store transfers.
- core_rdata  out  ELEMENT_BITS  data read from RAM.
- core_rvalid  out  1  core_rdata valid this cycle.
- core_wreq  out  1  asks the core for one word on core_wdata next cycle.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse after the last word of a transfer.

Behaviour:
- Reset and clocking: single clock, synchronous active-low reset. Reset values:
  - all outputs 0;
  - input index and output index 0;
  - sequencer mode register 0;
  - DMA idle;
  - RAM contents not reset.
- Memory map (localparams):
  - IN_FIRST = 0
  - W1_FIRST = 40 (FEATURES*CYCLES)
  - W2_FIRST = 104
  - OUT_FIRST = 168
- op_mode encoding:
  - 0 IDLE
  - 1 LOAD_W1: read WEIGHTS words from W1_FIRST.
  - 2 LOAD_W2: read WEIGHTS words from W2_FIRST.
  - 3 LOAD_IN: read FEATURES words from IN_FIRST + in_idx*FEATURES, then in_idx++.
  - 4 STORE_OUT: write OUT_WORDS words to OUT_FIRST + out_idx*OUT_WORDS, then out_idx++.
  - 5-7: treated as IDLE.
  - in_idx and out_idx wrap from CYCLES-1 to 0.
- Sequencer trigger:
  - Fires when sys_start=1, DMA idle, op_mode is 1-4 and op_mode != mode_q.
  - On fire: mode_q <= op_mode, and a one-cycle start pulse goes to the DMA with first_addr, count and direction (read for 1-3, write for 4).
  - op_mode of 0 or 5-7 sets mode_q <= 0.
  - The same mode issues again only after op_mode leaves it.
  - A change arriving while busy is acted on in the first idle cycle.
- DMA read transfer:
  - On start, latch the descriptor; busy=1 from the next cycle.
  - For k = 0..count-1, drive read address first_addr+k with oe=1, one word per cycle.
  - RAM output is registered: core_rdata/core_rvalid appear one cycle after each address.
  - done pulses in the cycle after the last core_rvalid; busy drops in that same cycle.
- DMA write transfer:
  - For k = 0..count-1, assert core_wreq for one cycle per word, back to back.
  - The core presents core_wdata one cycle later.
  - Write address (first_addr+k) and write enable are delayed one cycle to align with that data.
  - done pulses the cycle after the final write; busy drops in that same cycle.
- Addresses wrap modulo RAM_DEPTH.
- A start while busy is ignored.
- RAM:
  - Synchronous write when cs_in & we_in.
  - Synchronous read when cs_out & oe_out, into a registered data_out.
  - data_out holds its value when not reading.
  - A read and a write to the same address in the same cycle return the old data.
- Write-port mux:
  - sys_start=0: write port = host_we/host_addr/host_data; DMA writes blocked; no transfers issue.
  - sys_start=1: host inputs are ignored.
- Dropping sys_start mid-transfer aborts the transfer:
  - DMA returns to idle next cycle, without a done pulse;
  - mode_q, in_idx and out_idx are kept.
- Reset mid-transfer aborts the transfer immediately.

Decomposition:
- Package lstm_mem_pkg holds:
  - the op_mode enum;
  - ELEMENT_BITS and ADDR_BITS;
  - the memory-map localparams;
  - the transfer descriptor struct (first_addr, count, dir).
- Sub-module lstm_dpr is the RAM.
- Sequencer and DMA live in the top as two always_ff FSMs.
  - DMA states: IDLE, RD, WR, DONE.

Test Plan:
- Host preload: with sys_start=0, write addr 40+i = 4 for i<20, 3 for i<40, else 2.
  -> With sys_start=1 and op_mode=1, core_rvalid is high for 64 consecutive cycles; data is 4 (x20), 3 (x20), 2 (x24); done fires once.
- Host preload: inputs 1,2,3,4 at addresses 0-3 and 5,6,7,8 at addresses 4-7. op_mode sequence 3,0,3.
  -> The core receives 1,2,3,4 then 5,6,7,8, first word one cycle after the address.
- op_mode=4 with the core returning 8'hA0+k one cycle after each core_wreq.
  -> Addresses 168-175 hold A0-A7. A second STORE_OUT (after op_mode returns to 0) writes addresses 176-183.
- Ten LOAD_IN transfers, then an eleventh.
  -> The eleventh reads from address 0 again (in_idx wrap).
- During sys_start=0, op_mode=1 produces no transfer and busy stays 0. During sys_start=1, host_we=1 does not alter the RAM.
- Mid-read of LOAD_W1, drive reset_n=0 for one cycle.
  -> busy, core_rvalid and done are 0 next cycle. A later op_mode=1 restarts from address 40.
